serial_compl_unit: RTL and testbench
====================================

// Module: serial_compl_unit
// PURPOSE
//   Parametrised bit-serial complementer for LSB-first words of W bits.
//   Per word it computes pass-through, one's complement or two's complement.
//   It keeps its own word framing and a valid qualifier, assembles the parallel
//   result, and flags two's-complement overflow (negating the most negative value).
//   It sits between serial producers and consumers in the datapath.
// PARAMETERS
//   W     8    word width in bits, >= 2
//   CW    $clog2(W)    bit-index width (derived, do not override)
// PORTS
//   clk        in   1    clock, all state updates on posedge
//   rst        in   1    synchronous reset, active-high
//   mode       in   2    00 pass, 01 one's compl, 10/11 two's compl
//   bit_in     in   1    serial input bit, LSB first
//   in_valid   in   1    bit_in is valid this cycle (bit accepted)
//   bit_out    out  1    serial result bit (registered)
//   out_valid  out  1    bit_out valid
//   bit_idx    out  CW   index of next bit to be accepted within the word
//   word_out   out  W    last completed result word, held until the next completes
//   word_valid out  1    1-cycle pulse: word_out updated
//   ovf        out  1    with word_valid: two's mode and input was {1,0..0}
// BEHAVIOUR
//   - Reset (rst=1 at posedge): bit_out=0, out_valid=0, bit_idx=0, word_out=0,
//     word_valid=0, ovf=0. Internally seen_one=0, mode latch=00 and the shift register is 0.
//   - Reset mid-word discards the partial word. No word_valid is produced for it.
//   - Accept: a bit is accepted on a posedge with in_valid=1 and rst=0.
//     in_valid=0 is a stall: bit_idx, seen_one and the shift register hold.
//     out_valid=0 and word_valid=0 the next cycle. bit_out holds its last value.
//   - Mode latch: mode is sampled on the accepted bit with bit_idx==0 and used for
//     the whole word. Mode changes at any other bit are ignored until the next word.
//   - Result bit r for accepted bit b, where m is the mode used for this bit
//     (the fresh mode sample at idx 0, otherwise the latch):
//       pass: r=b.   ones: r=~b.
//       twos: r = seen_one ? ~b : b.   Then seen_one <= seen_one | b.
//   - Latency: r appears on bit_out with out_valid=1 in the cycle after acceptance.
//     Throughput is 1 bit/cycle; back-to-back words need no bubble.
//   - Framing: bit_idx increments per accepted bit and wraps W-1 -> 0.
//     On the accepted bit with bit_idx==W-1, seen_one clears so the next word
//     starts fresh.
//   - Assembly: sh <= {r, sh[W-1:1]} on each accepted bit. On bit W-1, the next cycle:
//     word_out={r, sh[W-1:1]}, word_valid=1 (same cycle as that bit's out_valid).
//   - ovf: on bit W-1 in two's mode, ovf <= (seen_one==0 && b==1), i.e. the input
//     was 100..0. ovf is valid only with word_valid and is 0 otherwise.
//     An all-zero input gives a zero result with ovf=0.
//   - rst has priority over in_valid in the same cycle.
// TESTING
//   1 rst=1 for 2 cycles with random bit_in/in_valid -> all outputs 0, bit_idx 0.
//   2 W=8, twos, 0x0C (bits 0,0,1,1,0,0,0,0) -> bit_out 0,0,1,0,1,1,1,1;
//     word_out=0xF4, ovf=0.
//   3 twos: 0x80 -> 0x80, ovf=1. Then 0x00 back-to-back -> 0x00, ovf=0, no bubble.
//   4 ones 0x5A -> 0xA5. pass 0x5A -> 0x5A. Mode flip to twos at bit 3 of the pass
//     word -> still 0x5A.
//   5 twos 0x0C with in_valid low for 3 cycles after bit 2 -> word_out=0xF4.
//     out_valid count = 8 and word_valid fires exactly once.
//   6 twos: 3 bits of 0x0F, then rst, then a full 0x01 -> word_out=0xFF, ovf=0.
//     No word_valid for the aborted word.

Source files
------------

// File: rtl/serial_compl_unit.sv
// serial_compl_unit
//   Bit-serial complementer for LSB-first words of W bits. Each word is passed
//   through, one's-complemented or two's-complemented according to the mode
//   sampled on its first accepted bit. The unit keeps its own word framing,
//   assembles the parallel result, and flags two's-complement overflow
//   (negation of the most negative value).
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high
//   mode       00 pass, 01 one's complement, 10/11 two's complement
//   bit_in     serial input bit, LSB first
//   in_valid   bit_in is accepted this cycle
//   bit_out    registered serial result bit
//   out_valid  bit_out carries a fresh result this cycle
//   bit_idx    index of the next bit to be accepted within the word
//   word_out   last completed result word, held until the next completes
//   word_valid one-cycle pulse when word_out is updated
//   ovf        with word_valid: two's mode and input was {1,0..0}
module serial_compl_unit #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          bit_in,
  input  logic          in_valid,
  output logic          bit_out,
  output logic          out_valid,
  output logic [CW-1:0] bit_idx,
  output logic [W-1:0]  word_out,
  output logic          word_valid,
  output logic          ovf
);

  typedef enum logic [1:0] {
    M_PASS     = 2'b00,
    M_ONES     = 2'b01,
    M_TWOS     = 2'b10,
    M_TWOS_ALT = 2'b11
  } mode_e;

  mode_e        mode_q;
  mode_e        mode_cur;
  logic         seen_one;
  logic [W-1:0] sh;
  logic         is_twos;
  logic         first_bit;
  logic         last_bit;
  logic         r;

  assign first_bit = (bit_idx == '0);
  assign last_bit  = (bit_idx == CW'(W - 1));

  // The first bit of a word uses the live mode input; later bits use the latch.
  assign mode_cur = first_bit ? mode_e'(mode) : mode_q;
  assign is_twos  = (mode_cur == M_TWOS) || (mode_cur == M_TWOS_ALT);

  always_comb begin
    r = bit_in;
    unique case (mode_cur)
      M_PASS:               r = bit_in;
      M_ONES:               r = ~bit_in;
      M_TWOS, M_TWOS_ALT:   r = seen_one ? ~bit_in : bit_in;
      default:              r = bit_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_out    <= 1'b0;
      out_valid  <= 1'b0;
      bit_idx    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      ovf        <= 1'b0;
      seen_one   <= 1'b0;
      mode_q     <= M_PASS;
      sh         <= '0;
    end else begin
      out_valid  <= in_valid;
      word_valid <= 1'b0;
      ovf        <= 1'b0;
      if (in_valid) begin
        bit_out <= r;
        sh      <= {r, sh[W-1:1]};
        if (first_bit) begin
          mode_q <= mode_e'(mode);
        end
        if (last_bit) begin
          bit_idx    <= '0;
          seen_one   <= 1'b0;
          word_out   <= {r, sh[W-1:1]};
          word_valid <= 1'b1;
          // Only input 100..0 reaches the MSB in two's mode with no earlier one.
          ovf        <= is_twos && !seen_one && bit_in;
        end else begin
          bit_idx <= bit_idx + CW'(1);
          if (is_twos) begin
            seen_one <= seen_one | bit_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_compl_unit.sv
// tb_serial_compl_unit
//   Self-checking bench for serial_compl_unit (W=8). A vector table of
//   {mode, input word, expected word, expected ovf} drives back-to-back words;
//   hand-written sequences cover mode flips, stalls and mid-word reset.
//   Expected bits and words go into queues when driven and are popped when
//   the DUT reports out_valid / word_valid.
module tb_serial_compl_unit;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          bit_in;
  logic          in_valid;
  logic          bit_out;
  logic          out_valid;
  logic [CW-1:0] bit_idx;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          ovf;

  serial_compl_unit #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .bit_in     (bit_in),
    .in_valid   (in_valid),
    .bit_out    (bit_out),
    .out_valid  (out_valid),
    .bit_idx    (bit_idx),
    .word_out   (word_out),
    .word_valid (word_valid),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
    logic [W-1:0] exp_w;
    logic         exp_ovf;
  } vec_t;

  vec_t       vecs[10];
  logic       exp_bits[$];
  logic [W:0] exp_words[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         ov_cnt   = 0;
  int         wv_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples 2 time units after each posedge.
  always @(posedge clk) begin
    #2;
    if (out_valid === 1'b1) begin
      ov_cnt++;
      if (exp_bits.size() == 0) begin
        n_checks++;
        $display("FAIL bit_unexpected: got out_valid=1 expected no output");
      end else begin
        check("bit_out", {31'd0, bit_out}, {31'd0, exp_bits.pop_front()});
      end
    end
    if (word_valid === 1'b1) begin
      wv_cnt++;
      if (exp_words.size() == 0) begin
        n_checks++;
        $display("FAIL word_unexpected: got word_valid=1 word_out=%0h expected no word", word_out);
      end else begin
        logic [W:0] e;
        e = exp_words.pop_front();
        check("word_out", {24'd0, word_out}, {24'd0, e[W-1:0]});
        check("ovf", {31'd0, ovf}, {31'd0, e[W]});
      end
    end else if (!rst) begin
      check("ovf_idle", {31'd0, ovf}, 32'd0);
    end
  end

  task automatic send_word(input logic [1:0] m, input logic [W-1:0] d,
                           input logic [W-1:0] exp_w, input logic exp_ovf,
                           input int flip_at, input logic [1:0] flip_m,
                           input int stall_after, input int stall_n);
    for (int i = 0; i < W; i++) begin
      if (stall_after >= 0 && i == stall_after + 1) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          in_valid = 1'b0;
          bit_in   = 1'($urandom);
        end
      end
      @(negedge clk);
      check("bit_idx", {29'd0, bit_idx}, i);
      mode     = (flip_at >= 0 && i >= flip_at) ? flip_m : m;
      bit_in   = d[i];
      in_valid = 1'b1;
      exp_bits.push_back(exp_w[i]);
      if (i == W - 1) exp_words.push_back({exp_ovf, exp_w});
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("words_drained", exp_words.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b10, 8'h0C, 8'hF4, 1'b0};
    vecs[1] = '{2'b10, 8'h80, 8'h80, 1'b1};
    vecs[2] = '{2'b10, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{2'b01, 8'h5A, 8'hA5, 1'b0};
    vecs[4] = '{2'b00, 8'h5A, 8'h5A, 1'b0};
    vecs[5] = '{2'b11, 8'h01, 8'hFF, 1'b0};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 1'b0};
    vecs[7] = '{2'b10, 8'hFF, 8'h01, 1'b0};
    vecs[8] = '{2'b00, 8'h80, 8'h80, 1'b0};
    vecs[9] = '{2'b01, 8'h80, 8'h7F, 1'b0};

    // Reset for two posedges with random traffic.
    rst = 1'b1; mode = 2'b00; bit_in = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      bit_in   = 1'($urandom);
      mode     = 2'($urandom);
    end
    @(negedge clk);
    check("rst_bit_out", {31'd0, bit_out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bit_idx", {29'd0, bit_idx}, 32'd0);
    check("rst_word_out", {24'd0, word_out}, 32'd0);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // Table vectors, all back-to-back.
    for (int v = 0; v < 10; v++)
      send_word(vecs[v].m, vecs[v].d, vecs[v].exp_w, vecs[v].exp_ovf, -1, 2'b00, -1, 0);
    drain();

    // Pass word with mode flipped to two's at bit 3: latched mode wins.
    send_word(2'b00, 8'h5A, 8'h5A, 1'b0, 3, 2'b10, -1, 0);
    drain();

    // Two's 0x0C with a 3-cycle stall after bit 2.
    ov_cnt = 0; wv_cnt = 0;
    send_word(2'b10, 8'h0C, 8'hF4, 1'b0, -1, 2'b00, 2, 3);
    drain();
    check("stall_out_valid_cnt", ov_cnt, 8);
    check("stall_word_valid_cnt", wv_cnt, 1);

    // Mid-word reset: 3 bits of two's 0x0F (results 1,0,0), then rst.
    ov_cnt = 0; wv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mode = 2'b10; bit_in = 1'b1; in_valid = 1'b1;
      exp_bits.push_back((i == 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("abort_bit_idx", {29'd0, bit_idx}, 32'd0);
    check("abort_word_out", {24'd0, word_out}, 32'd0);
    send_word(2'b10, 8'h01, 8'hFF, 1'b0, -1, 2'b00, -1, 0);
    drain();
    check("abort_word_valid_cnt", wv_cnt, 1);
    check("abort_out_valid_cnt", ov_cnt, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
